// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, default word width and an
// opcode legality helper used by the ALU and by anything that issues to it.
package alu_pkg;

    localparam int WORD_BITWIDTH_DEF = 32;

    localparam logic [3:0] OP_AND       = 4'b0000;
    localparam logic [3:0] OP_OR        = 4'b0001;
    localparam logic [3:0] OP_ADD       = 4'b0010;
    localparam logic [3:0] OP_XOR       = 4'b0011;
    localparam logic [3:0] OP_SLL       = 4'b0100;
    localparam logic [3:0] OP_SRL       = 4'b0101;
    localparam logic [3:0] OP_SUBTRACT  = 4'b0110;
    localparam logic [3:0] OP_LESS_THAN = 4'b0111;
    localparam logic [3:0] OP_JAL       = 4'b1000;

    // Encodings above JAL are reserved and never reach the ALU datapath.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= OP_JAL);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared execute-stage ALU: purely combinational, one operation per call.
// LESS_THAN is an unsigned compare that yields 0 when a<b and 1 otherwise;
// JAL forms a+b and always reports zero so callers can treat it as "taken".
module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int WORD_BITWIDTH = WORD_BITWIDTH_DEF
) (
    input  logic [3:0]               operation,
    input  logic [WORD_BITWIDTH-1:0] addend1,
    input  logic [WORD_BITWIDTH-1:0] addend2,
    output logic [WORD_BITWIDTH-1:0] result,
    output logic                     zero
);

    localparam logic [WORD_BITWIDTH-1:0] ONE = {{(WORD_BITWIDTH-1){1'b0}}, 1'b1};

    // Operation decode; shifts use the whole addend2 so amounts >= width give 0.
    always_comb begin
        result = '0;
        case (operation)
            OP_AND:       result = addend1 & addend2;
            OP_OR:        result = addend1 | addend2;
            OP_ADD:       result = addend1 + addend2;
            OP_XOR:       result = addend1 ^ addend2;
            OP_SLL:       result = addend1 << addend2;
            OP_SRL:       result = addend1 >> addend2;
            OP_SUBTRACT:  result = addend1 - addend2;
            OP_LESS_THAN: result = (addend1 < addend2) ? '0 : ONE;
            OP_JAL:       result = addend1 + addend2;
            default:      result = '0;
        endcase
        zero = (operation == OP_JAL) || (result == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between the main execute path
// (requester 0) and the branch/address path (requester 1). At most one
// request is issued per cycle; each requester owns a one-deep response
// register that holds its result until the requester drains it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WORD_BITWIDTH = WORD_BITWIDTH_DEF,
    parameter int NUM_REQ       = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0][3:0]               req_op,
    input  logic [NUM_REQ-1:0][WORD_BITWIDTH-1:0] req_a,
    input  logic [NUM_REQ-1:0][WORD_BITWIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]                    resp_valid,
    input  logic [NUM_REQ-1:0]                    resp_ready,
    output logic [NUM_REQ-1:0][WORD_BITWIDTH-1:0] resp_result,
    output logic [NUM_REQ-1:0]                    resp_zero,
    output logic [NUM_REQ-1:0]                    resp_illegal
);

    // Response registers and round-robin pointer.
    logic [NUM_REQ-1:0]                    resp_valid_q,   resp_valid_d;
    logic [NUM_REQ-1:0][WORD_BITWIDTH-1:0] resp_result_q,  resp_result_d;
    logic [NUM_REQ-1:0]                    resp_zero_q,    resp_zero_d;
    logic [NUM_REQ-1:0]                    resp_illegal_q, resp_illegal_d;
    logic                                  last_grant_q,   last_grant_d;

    // Arbitration and issue signals.
    logic [NUM_REQ-1:0]       slot_free;
    logic [NUM_REQ-1:0]       eligible;
    logic [NUM_REQ-1:0]       grant;
    logic                     grant_sel;
    logic [3:0]               alu_op;
    logic [WORD_BITWIDTH-1:0] alu_a;
    logic [WORD_BITWIDTH-1:0] alu_b;
    logic [WORD_BITWIDTH-1:0] alu_result;
    logic                     alu_zero;
    logic                     op_illegal;
    logic [WORD_BITWIDTH-1:0] issue_result;
    logic                     issue_zero;

    // Eligibility and round-robin grant; a slot being drained this cycle can
    // be refilled in the same cycle, and nothing is granted while in reset.
    always_comb begin
        slot_free = ~resp_valid_q | resp_ready;
        eligible  = req_valid & slot_free & {NUM_REQ{rst_n}};
        grant     = '0;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
        grant_sel = grant[1];
    end

    assign req_ready = grant;

    // Operand mux: idles on requester 0 when nothing is granted.
    always_comb begin
        alu_op = req_op[grant_sel];
        alu_a  = req_a[grant_sel];
        alu_b  = req_b[grant_sel];
    end

    alu_arbiter_alu #(
        .WORD_BITWIDTH (WORD_BITWIDTH)
    ) u_alu (
        .operation (alu_op),
        .addend1   (alu_a),
        .addend2   (alu_b),
        .result    (alu_result),
        .zero      (alu_zero)
    );

    // Reserved opcodes bypass the ALU output and report a fixed response.
    always_comb begin
        op_illegal   = !is_legal_op(alu_op);
        issue_result = op_illegal ? '0 : alu_result;
        issue_zero   = op_illegal | alu_zero;
    end

    // Response slot update: load on grant, otherwise clear on drain; the data
    // fields keep their last value after a drain.
    always_comb begin
        resp_valid_d   = resp_valid_q;
        resp_result_d  = resp_result_q;
        resp_zero_d    = resp_zero_q;
        resp_illegal_d = resp_illegal_q;
        last_grant_d   = last_grant_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                resp_valid_d[i]   = 1'b1;
                resp_result_d[i]  = issue_result;
                resp_zero_d[i]    = issue_zero;
                resp_illegal_d[i] = op_illegal;
            end else if (resp_ready[i]) begin
                resp_valid_d[i]   = 1'b0;
            end
        end
        if (grant != '0) begin
            last_grant_d = grant_sel;
        end
    end

    // State registers; last_grant resets to 1 so requester 0 wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q   <= '0;
            resp_result_q  <= '0;
            resp_zero_q    <= '0;
            resp_illegal_q <= '0;
            last_grant_q   <= 1'b1;
        end else begin
            resp_valid_q   <= resp_valid_d;
            resp_result_q  <= resp_result_d;
            resp_zero_q    <= resp_zero_d;
            resp_illegal_q <= resp_illegal_d;
            last_grant_q   <= last_grant_d;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_result  = resp_result_q;
    assign resp_zero    = resp_zero_q;
    assign resp_illegal = resp_illegal_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. Inputs change on the falling edge; the
// combinational req_ready is checked 1ns later and registered responses are
// checked on the following falling edge.
module tb_alu_arbiter;

    localparam int W = 32;

    logic              clk;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][3:0]   req_op;
    logic [1:0][W-1:0] req_a;
    logic [1:0][W-1:0] req_b;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [1:0][W-1:0] resp_result;
    logic [1:0]        resp_zero;
    logic [1:0]        resp_illegal;

    int checks;
    int errors;

    alu_arbiter #(.WORD_BITWIDTH(W), .NUM_REQ(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result  (resp_result),
        .resp_zero    (resp_zero),
        .resp_illegal (resp_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int idx, input logic [3:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        req_op[idx] = op;
        req_a[idx]  = a;
        req_b[idx]  = b;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        set_req(0, 4'b0010, 32'd1, 32'd1);
        set_req(1, 4'b0010, 32'd1, 32'd1);
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready);
        end
        checks++;
        if (resp_valid !== 2'b00 || resp_zero !== 2'b00 || resp_illegal !== 2'b00 || resp_result !== '0) begin
            errors++; $display("FAIL reset_outputs got v=%b z=%b i=%b r=%h exp all zero",
                               resp_valid, resp_zero, resp_illegal, resp_result);
        end
        @(negedge clk);
        req_valid = 2'b00;
        rst_n     = 1'b1;
    endtask

    task automatic test_add();
        @(negedge clk);
        resp_ready = 2'b11;
        req_valid  = 2'b01;
        set_req(0, 4'b0010, 32'd5, 32'd7);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL add_ready got=%b exp=01", req_ready);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b01 || resp_result[0] !== 32'd12 || resp_zero[0] !== 1'b0 || resp_illegal[0] !== 1'b0) begin
            errors++; $display("FAIL add_resp got v=%b r=%0d z=%b i=%b exp v=01 r=12 z=0 i=0",
                               resp_valid, resp_result[0], resp_zero[0], resp_illegal[0]);
        end
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b00) begin
            errors++; $display("FAIL add_drain got=%b exp=00", resp_valid);
        end
    endtask

    // Last grant before this test was requester 0, so the first conflict goes to 1.
    task automatic test_alternate();
        logic [1:0] exp_g [4];
        exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (resp_valid !== exp_g[k-1] || resp_result[exp_g[k-1][1]] !== '0 || resp_zero[exp_g[k-1][1]] !== 1'b1) begin
                    errors++; $display("FAIL alt_resp%0d got v=%b r=%h z=%b exp v=%b r=0 z=1", k-1,
                                       resp_valid, resp_result[exp_g[k-1][1]], resp_zero[exp_g[k-1][1]], exp_g[k-1]);
                end
            end
            if (k == 0) begin
                resp_ready = 2'b11;
                req_valid  = 2'b11;
                set_req(0, 4'b0110, 32'd9, 32'd9);
                set_req(1, 4'b0110, 32'd9, 32'd9);
            end
            if (k == 4) begin
                req_valid = 2'b00;
            end else begin
                #1;
                checks++;
                if (req_ready !== exp_g[k]) begin
                    errors++; $display("FAIL alt_grant%0d got=%b exp=%b", k, req_ready, exp_g[k]);
                end
            end
        end
    endtask

    task automatic test_ops();
        int         idx  [8];
        logic [3:0] op   [8];
        logic [W-1:0] a  [8];
        logic [W-1:0] b  [8];
        logic [W-1:0] er [8];
        logic       ez   [8];
        idx[0]=1; op[0]=4'b1000; a[0]=32'h100;      b[0]=32'd4;      er[0]=32'h104;      ez[0]=1'b1;
        idx[1]=0; op[1]=4'b0111; a[1]=32'd3;        b[1]=32'd8;      er[1]=32'd0;        ez[1]=1'b1;
        idx[2]=0; op[2]=4'b0111; a[2]=32'd8;        b[2]=32'd3;      er[2]=32'd1;        ez[2]=1'b0;
        idx[3]=1; op[3]=4'b0100; a[3]=32'd1;        b[3]=32'd33;     er[3]=32'd0;        ez[3]=1'b1;
        idx[4]=1; op[4]=4'b0101; a[4]=32'h80000000; b[4]=32'd31;     er[4]=32'd1;        ez[4]=1'b0;
        idx[5]=0; op[5]=4'b0000; a[5]=32'hF0F0;     b[5]=32'hFF00;   er[5]=32'hF000;     ez[5]=1'b0;
        idx[6]=1; op[6]=4'b0001; a[6]=32'h0F;       b[6]=32'hF0;     er[6]=32'hFF;       ez[6]=1'b0;
        idx[7]=0; op[7]=4'b0110; a[7]=32'd3;        b[7]=32'd5;      er[7]=32'hFFFFFFFE; ez[7]=1'b0;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (resp_valid[idx[k-1]] !== 1'b1 || resp_result[idx[k-1]] !== er[k-1] ||
                    resp_zero[idx[k-1]] !== ez[k-1] || resp_illegal[idx[k-1]] !== 1'b0) begin
                    errors++; $display("FAIL op%0d got v=%b r=%h z=%b i=%b exp v=1 r=%h z=%b i=0", k-1,
                                       resp_valid[idx[k-1]], resp_result[idx[k-1]], resp_zero[idx[k-1]],
                                       resp_illegal[idx[k-1]], er[k-1], ez[k-1]);
                end
            end
            if (k == 8) begin
                req_valid = 2'b00;
            end else begin
                req_valid = (idx[k] == 1) ? 2'b10 : 2'b01;
                set_req(idx[k], op[k], a[k], b[k]);
                #1;
                checks++;
                if (req_ready !== req_valid) begin
                    errors++; $display("FAIL op%0d_ready got=%b exp=%b", k, req_ready, req_valid);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        resp_ready = 2'b10;
        req_valid  = 2'b01;
        set_req(0, 4'b0010, 32'd1, 32'd2);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL bp_first got=%b exp=01", req_ready);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b01 || resp_result[0] !== 32'd3) begin
            errors++; $display("FAIL bp_resp0 got v=%b r=%0d exp v=01 r=3", resp_valid, resp_result[0]);
        end
        req_valid = 2'b11;
        set_req(0, 4'b0010, 32'd10, 32'd20);
        set_req(1, 4'b0011, 32'hF0, 32'hFF);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL bp_block1 got=%b exp=10", req_ready);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b11 || resp_result[1] !== 32'h0F || resp_result[0] !== 32'd3) begin
            errors++; $display("FAIL bp_hold1 got v=%b r1=%h r0=%0d exp v=11 r1=0f r0=3",
                               resp_valid, resp_result[1], resp_result[0]);
        end
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL bp_block2 got=%b exp=10", req_ready);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b11 || resp_result[0] !== 32'd3) begin
            errors++; $display("FAIL bp_hold2 got v=%b r0=%0d exp v=11 r0=3", resp_valid, resp_result[0]);
        end
        resp_ready = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL bp_release got=%b exp=01", req_ready);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b01 || resp_result[0] !== 32'd30) begin
            errors++; $display("FAIL bp_refill got v=%b r0=%0d exp v=01 r0=30", resp_valid, resp_result[0]);
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        @(negedge clk);
        resp_ready = 2'b11;
        req_valid  = 2'b10;
        set_req(1, 4'b0010, 32'd2, 32'd2);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL ill_pre got=%b exp=10", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b01;
        set_req(0, 4'b1011, 32'd5, 32'd6);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL ill_ready got=%b exp=01", req_ready);
        end
        @(negedge clk);
        checks++;
        if (resp_valid[0] !== 1'b1 || resp_result[0] !== '0 || resp_zero[0] !== 1'b1 || resp_illegal[0] !== 1'b1) begin
            errors++; $display("FAIL ill_resp got v=%b r=%h z=%b i=%b exp v=1 r=0 z=1 i=1",
                               resp_valid[0], resp_result[0], resp_zero[0], resp_illegal[0]);
        end
        req_valid = 2'b11;
        set_req(0, 4'b0010, 32'd1, 32'd1);
        set_req(1, 4'b0010, 32'd1, 32'd1);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL ill_lastgrant got=%b exp=10", req_ready);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b10 || resp_illegal[1] !== 1'b0) begin
            errors++; $display("FAIL ill_after got v=%b i1=%b exp v=10 i1=0", resp_valid, resp_illegal[1]);
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        resp_ready = 2'b00;
        req_valid  = 2'b11;
        set_req(0, 4'b0010, 32'd1, 32'd1);
        set_req(1, 4'b0010, 32'd1, 32'd1);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL ar_g0 got=%b exp=01", req_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== 2'b01 || req_ready !== 2'b10) begin
            errors++; $display("FAIL ar_g1 got v=%b rdy=%b exp v=01 rdy=10", resp_valid, req_ready);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b11) begin
            errors++; $display("FAIL ar_full got=%b exp=11", resp_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 2'b00 || resp_result !== '0 || resp_zero !== 2'b00 ||
            resp_illegal !== 2'b00 || req_ready !== 2'b00) begin
            errors++; $display("FAIL ar_cleared got v=%b r=%h z=%b i=%b rdy=%b exp all zero",
                               resp_valid, resp_result, resp_zero, resp_illegal, req_ready);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        resp_ready = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL ar_first_conflict got=%b exp=01", req_ready);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b01 || resp_result[0] !== 32'd2) begin
            errors++; $display("FAIL ar_post got v=%b r0=%0d exp v=01 r0=2", resp_valid, resp_result[0]);
        end
        req_valid = 2'b00;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_alternate();
        test_ops();
        test_backpressure();
        test_illegal();
        test_async_reset();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single execute-stage ALU between two requesters: requester 0 is the main execute path, requester 1 is the branch/address-calculation path. Each cycle at most one request is granted, with round-robin priority. The granted operands are driven through one combinational ALU instance. The result and zero flag are captured into a per-requester response register, which holds until that requester consumes it.

## Interface
- WORD_BITWIDTH, 32, operand and result width
- NUM_REQ, 2, number of requesters (fixed at 2 for this revision)
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per requester: request present
- req_ready  out  2  per requester: request accepted this cycle
- req_op  in  2x4  per requester: ALU operation code
- req_a  in  2xWORD_BITWIDTH  per requester: addend1
- req_b  in  2xWORD_BITWIDTH  per requester: addend2
- resp_valid  out  2  per requester: response register holds data
- resp_ready  in  2  per requester: response consumed this cycle
- resp_result  out  2xWORD_BITWIDTH  per requester: registered ALU result
- resp_zero  out  2  per requester: registered zero flag
- resp_illegal  out  2  per requester: registered illegal-opcode flag

## Operation
- Legal opcodes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUBTRACT 0110, LESS_THAN 0111, JAL 1000.
- ALU semantics come unchanged from the shared ALU:
  - LESS_THAN yields 0 when a<b (unsigned) and 1 otherwise.
  - JAL yields a+b.
  - zero = (op==JAL) or (result==0).
  - Shifts use the full b value.
- Illegal opcodes (1001–1111) are accepted as normal requests. The ALU is not used for them. The response is result=0, zero=1, illegal=1.
- Slot i is free when !resp_valid[i] or resp_ready[i] (same-cycle drain and refill allowed).
- Eligible[i] = req_valid[i] and slot i free.
- Grant:
  - Only one requester eligible: grant it.
  - Both eligible: grant the requester that is not last_grant.
  - None eligible: no grant.
- req_ready[i] = grant[i]. It is combinational from req_valid and resp_ready. Requesters must not make req_valid depend on req_ready.
- The ALU operand mux selects the granted requester. With no grant it selects requester 0, and its output is ignored.
- On grant i at a clock edge:
  - resp_result[i], resp_zero[i] and resp_illegal[i] are loaded.
  - resp_valid[i] is set.
  - last_grant is set to i.
- A response is cleared only when resp_ready[i] is high and requester i is not granted in the same cycle. The register then shows resp_valid=0; the data fields keep their last value.
- last_grant changes only on a grant.

## Timing
- Reset values (asynchronous, on rst_n low):
  - resp_valid=0, resp_result=0, resp_zero=0, resp_illegal=0.
  - last_grant=1, so requester 0 wins the first conflict.
- Reset mid-operation drops any pending response; no request is granted while rst_n is low.
- Latency: a request accepted at edge N has its response visible after edge N (1 cycle). Responses are registered only.
- Throughput: 1 op/cycle aggregate. Each requester sustains 1 op/cycle when it is alone and its response is drained every cycle.
- Both requesters continuously valid with slots drained each cycle: grants alternate 0,1,0,1…
- Backpressure: resp_ready[i]=0 with resp_valid[i]=1 blocks requester i only. The other requester may be granted every cycle.
- Simultaneous drain and refill of slot i: the new data replaces the old, and resp_valid stays 1.

## Structure
- Shared package alu_pkg holds:
  - opcode constants (AND…JAL)
  - WORD_BITWIDTH default
  - an is_legal_op function
- One sub-module instance: ALU (existing shared ALU), operation/addend1/addend2 driven from the grant mux.
- Arbiter logic lives in one module:
  - round-robin pointer, grant logic, two response registers
  - roughly 150–200 RTL lines

## Test plan
- Reset, then req0 valid with op=0010, a=5, b=7; resp_ready=1 → req_ready[0]=1 in that cycle; next cycle resp_valid[0]=1, result=12, zero=0.
- Both valid every cycle, op 0110 with a=b=9 on both, resp_ready=11 → grants 0,1,0,1; each response has result=0, zero=1.
- req1 JAL a=0x100, b=4 → result=0x104, zero=1. req0 LESS_THAN a=3, b=8 → result=0.
- Hold resp_ready[0]=0 after one response → req_ready[0]=0 on a further req0 request, while req1 is granted each cycle. Release resp_ready[0] → the pending req0 is granted the same cycle.
- req0 op=1011 → result=0, zero=1, illegal=1; last_grant updates.
- Assert rst_n=0 asynchronously while both responses are valid → resp_valid=00 immediately, all outputs 0. The first conflict after release goes to requester 0.
